n64_region_mapper: RTL and testbench

Parametrised, registered successor to the fixed N64 PI bank decoder. Tracks the current PI bus address itself (ALEH/ALEL latching plus auto-increment per 16-bit transfer) and decodes it against a runtime-programmable table of `NUM_REGIONS` address windows. Each window carries its own bank, prefetch flag and translation offset. It sits between the N64 PI front end and the bank arbiter, which consumes `o_bank`, `o_translated_address` and `o_bank_prefetch`.

---
 rtl/n64_region_mapper_if.sv | 33 +++
 rtl/n64_region_mapper.sv | 126 ++++++++++++
 tb/tb_n64_region_mapper.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/n64_region_mapper_if.sv
// rtl/n64_region_mapper_if.sv - PI address tracking and region decode bus between front end and mapper
interface n64_region_mapper_if #(
    parameter int ADDR_W = 26,
    parameter int IDX_W  = 3
);
    logic [15:0]       i_ad;
    logic              i_aleh;
    logic              i_alel;
    logic              i_increment;
    logic              i_cfg_write;
    logic [IDX_W-1:0]  i_cfg_index;
    logic [1:0]        i_cfg_field;
    logic [31:0]       i_cfg_data;

    logic [31:0]       o_address;
    logic [ADDR_W-1:0] o_translated_address;
    logic [3:0]        o_bank;
    logic              o_bank_prefetch;
    logic [IDX_W-1:0]  o_region;
    logic              o_valid;

    modport master (
        output i_ad, i_aleh, i_alel, i_increment,
        output i_cfg_write, i_cfg_index, i_cfg_field, i_cfg_data,
        input  o_address, o_translated_address, o_bank, o_bank_prefetch, o_region, o_valid
    );

    modport slave (
        input  i_ad, i_aleh, i_alel, i_increment,
        input  i_cfg_write, i_cfg_index, i_cfg_field, i_cfg_data,
        output o_address, o_translated_address, o_bank, o_bank_prefetch, o_region, o_valid
    );
endinterface

// File: rtl/n64_region_mapper.sv
// rtl/n64_region_mapper.sv - PI address tracker with programmable region table and registered bank decode
module n64_region_mapper #(
    parameter int         NUM_REGIONS  = 8,
    parameter int         ADDR_W       = 26,
    parameter int         IDX_W        = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1,
    parameter logic [3:0] BANK_INVALID = 4'hF
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    n64_region_mapper_if.slave   bus
);

    logic [31:0]       address_q;

    logic [31:0]       base_q   [NUM_REGIONS];
    logic [ADDR_W-1:0] offset_q [NUM_REGIONS];
    logic [4:0]        size_q   [NUM_REGIONS];
    logic [3:0]        bank_q   [NUM_REGIONS];
    logic              pf_q     [NUM_REGIONS];
    logic              en_q     [NUM_REGIONS];

    logic [ADDR_W-1:0] xlat_q;
    logic [3:0]        out_bank_q;
    logic              out_pf_q;
    logic [IDX_W-1:0]  region_q;
    logic              valid_q;

    logic              latch_ev;
    logic              cfg_accept;
    logic              any_event;

    logic [ADDR_W-1:0] hit_xlat;
    logic [3:0]        hit_bank;
    logic              hit_pf;
    logic [IDX_W-1:0]  hit_idx;
    logic [31:0]       mask;

    assign latch_ev   = bus.i_aleh | bus.i_alel;
    assign cfg_accept = bus.i_cfg_write && (bus.i_cfg_field != 2'd3)
                        && (int'(bus.i_cfg_index) < NUM_REGIONS);
    assign any_event  = latch_ev | bus.i_increment | cfg_accept;

    // Stage 1: address tracking; a latch of either half overrides any increment.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            address_q <= 32'h0;
        end else if (latch_ev) begin
            if (bus.i_aleh) address_q[31:16] <= bus.i_ad;
            if (bus.i_alel) address_q[15:0]  <= bus.i_ad;
        end else if (bus.i_increment) begin
            address_q <= address_q + 32'd2;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                base_q[i]   <= 32'h0;
                offset_q[i] <= '0;
                size_q[i]   <= 5'd0;
                bank_q[i]   <= 4'd0;
                pf_q[i]     <= 1'b0;
                en_q[i]     <= 1'b0;
            end
        end else if (cfg_accept) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                if (bus.i_cfg_index == IDX_W'(i)) begin
                    case (bus.i_cfg_field)
                        2'd0: base_q[i]   <= bus.i_cfg_data;
                        2'd1: offset_q[i] <= bus.i_cfg_data[ADDR_W-1:0];
                        2'd2: begin
                            en_q[i]   <= bus.i_cfg_data[12];
                            pf_q[i]   <= bus.i_cfg_data[11];
                            bank_q[i] <= bus.i_cfg_data[8:5];
                            size_q[i] <= bus.i_cfg_data[4:0];
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Ascending scan so the highest-indexed hitting region ends up winning.
    always_comb begin
        hit_xlat = '0;
        hit_bank = BANK_INVALID;
        hit_pf   = 1'b0;
        hit_idx  = '0;
        mask     = 32'h0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (en_q[i] && ((address_q >> size_q[i]) == (base_q[i] >> size_q[i]))) begin
                mask     = ~(32'hFFFF_FFFF << size_q[i]);
                hit_xlat = (address_q[ADDR_W-1:0] & mask[ADDR_W-1:0]) + offset_q[i];
                hit_bank = bank_q[i];
                hit_pf   = pf_q[i];
                hit_idx  = IDX_W'(i);
            end
        end
    end

    // Stage 2: decode registers; valid only once the address and table held still for an edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            xlat_q     <= '0;
            out_bank_q <= BANK_INVALID;
            out_pf_q   <= 1'b0;
            region_q   <= '0;
            valid_q    <= 1'b0;
        end else begin
            xlat_q     <= hit_xlat;
            out_bank_q <= hit_bank;
            out_pf_q   <= hit_pf;
            region_q   <= hit_idx;
            valid_q    <= ~any_event;
        end
    end

    assign bus.o_address            = address_q;
    assign bus.o_translated_address = xlat_q;
    assign bus.o_bank               = out_bank_q;
    assign bus.o_bank_prefetch      = out_pf_q;
    assign bus.o_region             = region_q;
    assign bus.o_valid              = valid_q;

endmodule

// File: tb/tb_n64_region_mapper.sv
// tb/tb_n64_region_mapper.sv - directed self-checking bench for n64_region_mapper
module tb_n64_region_mapper;

    localparam int         NUM_REGIONS = 6;
    localparam int         ADDR_W      = 26;
    localparam int         IDX_W       = 3;
    localparam logic [3:0] BINV        = 4'hF;
    localparam logic [3:0] B_ROM = 4'd1, B_CART = 4'd2, B_EEP = 4'd4, B_SD = 4'd5, B_DD = 4'd6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vecs = 0;
    int   errs = 0;

    n64_region_mapper_if #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) bus ();

    n64_region_mapper #(.NUM_REGIONS(NUM_REGIONS), .ADDR_W(ADDR_W)) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.i_ad        = 16'h0;
        bus.i_aleh      = 1'b0;
        bus.i_alel      = 1'b0;
        bus.i_increment = 1'b0;
        bus.i_cfg_write = 1'b0;
        bus.i_cfg_index = '0;
        bus.i_cfg_field = 2'd0;
        bus.i_cfg_data  = 32'h0;
    endtask

    task automatic cfg(input logic [IDX_W-1:0] idx, input logic [1:0] field, input logic [31:0] data);
        bus.i_cfg_write = 1'b1;
        bus.i_cfg_index = idx;
        bus.i_cfg_field = field;
        bus.i_cfg_data  = data;
        cycle();
        clear_inputs();
    endtask

    task automatic latch(input logic [15:0] hi, input logic [15:0] lo);
        bus.i_aleh = 1'b1;
        bus.i_ad   = hi;
        cycle();
        bus.i_aleh = 1'b0;
        bus.i_alel = 1'b1;
        bus.i_ad   = lo;
        cycle();
        clear_inputs();
    endtask

    task automatic check_decode(input string tag, input logic [3:0] bank, input logic [31:0] xlat,
                                input logic pf, input logic [IDX_W-1:0] region);
        chk({tag, "_valid"},  32'(bus.o_valid), 32'd1);
        chk({tag, "_bank"},   32'(bus.o_bank), 32'(bank));
        chk({tag, "_xlat"},   32'(bus.o_translated_address), xlat);
        chk({tag, "_pf"},     32'(bus.o_bank_prefetch), 32'(pf));
        chk({tag, "_region"}, 32'(bus.o_region), 32'(region));
    endtask

    initial begin
        clear_inputs();
        repeat (2) cycle();
        rst = 1'b0;

        // Region 4 covers the whole space, so reset clearing the table is observable.
        cfg(3'd4, 2'd2, 32'h0000_107F);
        bus.i_increment = 1'b1;
        repeat (3) cycle();
        chk("pre_reset_addr", bus.o_address, 32'h0000_0006);
        chk("inc_stream_valid", 32'(bus.o_valid), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_addr", bus.o_address, 32'h0);
        chk("async_rst_bank", 32'(bus.o_bank), 32'(BINV));
        chk("async_rst_valid", 32'(bus.o_valid), 32'd0);
        cycle();
        clear_inputs();
        rst = 1'b0;
        chk("rst_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_bank", 32'(bus.o_bank), 32'(BINV));
        chk("rst_addr", bus.o_address, 32'h0);
        chk("rst_region", 32'(bus.o_region), 32'd0);
        chk("rst_xlat", 32'(bus.o_translated_address), 32'd0);
        cycle();
        check_decode("rst_table_cleared", BINV, 32'h0, 1'b0, 3'd0);

        // ROM window; cfg_data[10:9] set to show they are ignored for bank
        cfg(3'd0, 2'd0, 32'h1000_0000);
        cfg(3'd0, 2'd1, 32'h0);
        cfg(3'd0, 2'd2, 32'h0000_1E3A);
        latch(16'h1000, 16'h0010);
        chk("rom_addr", bus.o_address, 32'h1000_0010);
        chk("rom_latency_valid", 32'(bus.o_valid), 32'd0);
        cycle();
        check_decode("rom", B_ROM, 32'h10, 1'b1, 3'd0);

        // EEPROM window top edge then one past it
        cfg(3'd3, 2'd0, 32'h1E00_4000);
        cfg(3'd3, 2'd1, 32'h0);
        cfg(3'd3, 2'd2, 32'h0000_108B);
        latch(16'h1E00, 16'h47FE);
        cycle();
        check_decode("eep_in", B_EEP, 32'h7FE, 1'b0, 3'd3);
        bus.i_increment = 1'b1;
        cycle();
        clear_inputs();
        chk("eep_inc_valid", 32'(bus.o_valid), 32'd0);
        cycle();
        chk("eep_inc_addr", bus.o_address, 32'h1E00_4800);
        check_decode("eep_out", BINV, 32'h0, 1'b0, 3'd0);

        // Overlap: region 5 (SD, 1 KiB) sits inside region 1 (CART, 16 KiB)
        cfg(3'd1, 2'd0, 32'h1E00_0000);
        cfg(3'd1, 2'd2, 32'h0000_104E);
        cfg(3'd5, 2'd0, 32'h1E00_0000);
        cfg(3'd5, 2'd2, 32'h0000_10AA);
        latch(16'h1E00, 16'h0100);
        cycle();
        check_decode("ovl_sd", B_SD, 32'h100, 1'b0, 3'd5);
        latch(16'h1E00, 16'h0800);
        cycle();
        check_decode("ovl_cart", B_CART, 32'h800, 1'b0, 3'd1);

        // DDIPL offset and ADDR_W carry wrap
        cfg(3'd2, 2'd0, 32'h0600_0000);
        cfg(3'd2, 2'd1, 32'h03C0_0000);
        cfg(3'd2, 2'd2, 32'h0000_10D6);
        latch(16'h0600, 16'h0004);
        cycle();
        check_decode("dd_off", B_DD, 32'h03C0_0004, 1'b0, 3'd2);
        cfg(3'd2, 2'd1, 32'h03FF_FFFC);
        chk("dd_cfg_valid", 32'(bus.o_valid), 32'd0);
        cycle();
        check_decode("dd_wrap", B_DD, 32'h0, 1'b0, 3'd2);

        // Latch and increment together: latch wins
        bus.i_aleh      = 1'b1;
        bus.i_alel      = 1'b1;
        bus.i_increment = 1'b1;
        bus.i_ad        = 16'h1234;
        cycle();
        clear_inputs();
        chk("latch_over_inc_addr", bus.o_address, 32'h1234_1234);
        cycle();
        chk("latch_over_inc_valid", 32'(bus.o_valid), 32'd1);

        // 32-bit wrap on increment
        latch(16'hFFFF, 16'hFFFE);
        bus.i_increment = 1'b1;
        cycle();
        clear_inputs();
        chk("wrap_addr", bus.o_address, 32'h0);
        cycle();
        chk("wrap_valid", 32'(bus.o_valid), 32'd1);

        // Disabling the active region drops the hit on the next decode
        latch(16'h1000, 16'h0010);
        cycle();
        check_decode("dis_before", B_ROM, 32'h10, 1'b1, 3'd0);
        cfg(3'd0, 2'd2, 32'h0000_083A);
        chk("dis_cfg_valid", 32'(bus.o_valid), 32'd0);
        cycle();
        check_decode("dis_after", BINV, 32'h0, 1'b0, 3'd0);

        // Out-of-range index and reserved field are ignored and do not drop valid
        cfg(3'd6, 2'd2, 32'h0000_107F);
        chk("oob_valid", 32'(bus.o_valid), 32'd1);
        cfg(3'd0, 2'd3, 32'h0000_1FFF);
        chk("rsvd_valid", 32'(bus.o_valid), 32'd1);
        cycle();
        check_decode("oob_rsvd", BINV, 32'h0, 1'b0, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
